lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the core's memory request port and the 32-bit, 24-bit-word-address data RAM.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Byte lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lane;
      SZ_H:    lane_mask = 4'b0011 << lane;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and store merge into a base word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] base_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [15:0] ld_half;
  logic [3:0]  mask;
  logic [31:0] bit_mask;
  logic [31:0] rep;

  assign ld_half = 16'(rdata_i >> {lane_i, 3'b000});

  // Load path: right-justify the addressed lanes and extend to 32 bits.
  always_comb begin
    load_o = rdata_i;
    case (size_i)
      SZ_B: load_o = unsigned_i ? {24'h0, ld_half[7:0]} : {{24{ld_half[7]}}, ld_half[7:0]};
      SZ_H: load_o = unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_o = rdata_i;
    endcase
  end

  // Store path: replicate store data across lanes, then keep only the addressed lanes.
  always_comb begin
    mask     = lane_mask(size_i, lane_i);
    bit_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    case (size_i)
      SZ_B:    rep = {4{wdata_i[7:0]}};
      SZ_H:    rep = {2{wdata_i[15:0]}};
      default: rep = wdata_i;
    endcase
    merge_o = (rep & bit_mask) | (base_i & ~bit_mask);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: request check, RAM access sequencing and response handshake.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        ram_wbe,
  output logic [3:0]        ram_rbe,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata
);

  lsu_state_e         state_q, state_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W+1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        base_q, base_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               req_bad;
  logic [31:0]        ld_data;
  logic [31:0]        st_merge;

  lsu_lane_align u_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .rdata_i    (ram_rdata),
    .base_i     (base_q),
    .wdata_i    (wdata_q),
    .load_o     (ld_data),
    .merge_o    (st_merge)
  );

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // State and captured-request registers; RAM strobes follow state so reset kills them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      base_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture and RAM/handshake outputs.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    base_d     = base_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_wbe    = 4'h0;
    ram_rbe    = 4'h0;
    ram_wen    = 1'b0;

    req_bad = (req_size == SZ_X)
           || (req_size == SZ_H && req_addr[0])
           || (req_size == SZ_W && req_addr[1:0] != 2'b00)
           || ((req_addr >> (ADDR_W + 2)) != '0);

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_bad;
          if (req_bad)                          state_d = ST_RESP;
          else if (!req_we || req_size != SZ_W) state_d = ST_RD;
          else                                  state_d = ST_WR;
        end
      end
      ST_RD: begin
        ram_rbe  = 4'hF;
        ram_addr = addr_q[ADDR_W+1:2];
        if (we_q) begin
          base_d  = ram_rdata;
          state_d = ST_WR;
        end else begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        // Word stores see a full lane mask, so the merge output is the store data itself.
        ram_wen   = 1'b1;
        ram_wbe   = 4'hF;
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = st_merge;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural RAM and reference model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [23:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [3:0]  ram_wbe, ram_rbe;
  logic        ram_wen;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(24), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wbe(ram_wbe), .ram_rbe(ram_rbe),
    .ram_wen(ram_wen), .ram_rdata(ram_rdata)
  );

  // RAM model: 256 words, aliased on the low word-address bits; bench preload port.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  assign ram_rdata = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (ram_wen)     mem[ram_addr[7:0]] <= ram_wdata;
    else if (pre_we) mem[pre_idx]       <= pre_val;
  end

  int unsigned wen_cnt = 0, rbe_cnt = 0, wbe_bad = 0;
  always @(posedge clk) begin
    if (ram_wen) wen_cnt <= wen_cnt + 1;
    if (ram_rbe != 4'h0) rbe_cnt <= rbe_cnt + 1;
    if (ram_wen && ram_wbe != 4'hF) wbe_bad <= wbe_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned idx, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 8'(idx); pre_val = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model straight from the access rules, then drive and check one transaction.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int unsigned hold, output logic [31:0] got);
    int unsigned nb, off, idx, lat, w0, r0, b0, exp_lat, exp_r, exp_w;
    logic exp_err;
    logic [31:0] w, exp_rd;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = addr % 4;
    idx = (addr / 4) % 256;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
              (sz == 2'd2 && addr % 4 != 0) || (addr >= 32'h0400_0000);
    exp_rd = 32'h0;
    if (exp_err) begin
      exp_lat = 1; exp_r = 0; exp_w = 0;
    end else if (!we) begin
      exp_lat = 2; exp_r = 1; exp_w = 0;
      w = ref_mem[idx];
      for (int unsigned i = 0; i < nb; i++)
        exp_rd = exp_rd | (((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
      if (!uns && nb < 4 && exp_rd >= (32'h1 << (8 * nb - 1)))
        exp_rd = exp_rd - (32'h1 << (8 * nb));
    end else begin
      exp_lat = (nb == 4) ? 2 : 3; exp_r = (nb == 4) ? 0 : 1; exp_w = 1;
      w = ref_mem[idx];
      for (int unsigned i = 0; i < nb; i++)
        w = (w & ~(32'hFF << (8 * (off + i)))) | (((wd >> (8 * i)) & 32'hFF) << (8 * (off + i)));
      ref_mem[idx] = w;
    end

    @(negedge clk);
    check("req_ready_idle", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    w0 = wen_cnt; r0 = rbe_cnt; b0 = wbe_bad;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    got = resp_rdata;
    if (!resp_valid) begin
      pulse_reset();
      return;
    end
    check("rdata", resp_rdata, exp_rd);
    check("err", {31'h0, resp_err}, {31'h0, exp_err});
    check("wen_cycles", wen_cnt - w0, exp_w);
    check("rbe_cycles", rbe_cnt - r0, exp_r);
    check("wbe_full", wbe_bad - b0, 0);
    check("req_ready_busy", {31'h0, req_ready}, 32'h0);
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", {31'h0, resp_err}, {31'h0, exp_err});
      check("hold_ready", {31'h0, req_ready}, 32'h0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_done", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] got, a;
    logic [1:0]  sz;
    int unsigned m, nb;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #12;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_wen", {31'h0, ram_wen}, 32'h0);
    check("rst_rbe", {28'h0, ram_rbe}, 32'h0);
    check("rst_wbe", {28'h0, ram_wbe}, 32'h0);
    check("rst_addr", {8'h0, ram_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 256; i++) preload(i, $urandom);
    preload(32'h40, 32'h80FF_1234);

    do_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, got); check("LB", got, 32'hFFFF_FF80);
    do_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, got); check("LBU", got, 32'h0000_0080);
    do_op(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 0, got); check("LH", got, 32'hFFFF_80FF);
    do_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, got); check("LW", got, 32'h80FF_1234);
    do_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344, 0, got);
    do_op(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00AB, 0, got);
    check("SB_word", mem[32'h40], 32'h1122_AB44);
    do_op(1'b1, 2'd2, 1'b0, 32'h200, 32'hDEAD_BEEF, 5, got); check("SW_rdata", got, 32'h0);
    check("SW_word", mem[32'h80], 32'hDEAD_BEEF);
    do_op(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, got);
    do_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, got);
    do_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, got);
    do_op(1'b1, 2'd0, 1'b0, 32'h0400_0000, 32'h55, 0, got);
    do_op(1'b0, 2'd0, 1'b1, 32'h03FF_FFFF, 32'h0, 0, got);
    do_op(1'b1, 2'd1, 1'b0, 32'h03FF_FFFE, 32'hBEEF, 0, got);

    // Reset during WR of a word store: strobe must drop immediately.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h300; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #2;
    req_valid = 1'b0;
    check("wr_before_rst", {31'h0, ram_wen}, 32'h1);
    rst_n = 1'b0; #1;
    check("wen_async_drop", {31'h0, ram_wen}, 32'h0);
    check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mid_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    do_op(1'b1, 2'd2, 1'b0, 32'h300, 32'h0BAD_C0DE, 0, got);

    // Reset during RD of a byte store leaves memory untouched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h205; req_wdata = 32'h77;
    @(posedge clk); #2;
    req_valid = 1'b0;
    check("rd_before_rst", {28'h0, ram_rbe}, 32'hF);
    rst_n = 1'b0; #1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rd_rst_mem", mem[32'h81], ref_mem[32'h81]);

    for (int unsigned n = 0; n < 150; n++) begin
      sz = (($urandom_range(0, 99)) < 6) ? 2'd3 : 2'($urandom_range(0, 2));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      m  = $urandom_range(0, 9);
      if (m < 7) begin
        a = 32'($urandom_range(0, 1023));
        if (m < 6 && sz != 2'd3) a = a & ~32'(nb - 1);
      end else if (m == 7) a = $urandom;
      else if (m == 8)     a = 32'h03FF_FFFC + 32'($urandom_range(0, 3));
      else                 a = 32'h0400_0000 + 32'($urandom_range(0, 3));
      do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            $urandom_range(0, 2), got);
    end

    for (int unsigned i = 0; i < 256; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
